// File: rtl/width_pkg.sv
// Shared definitions for the byte packer/unpacker pair: word/byte widths,
// FSM state encodings and the byte-lane select helper.
package width_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_e;

  // Returns the byte of w that belongs in the requested slot (first or second)
  // given the configured emission order.
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic msb_first,
                                                  input logic first_slot);
    return (msb_first == first_slot) ? w[WORD_W-1 -: BYTE_W] : w[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/width_16to8_if.sv
// Word-in / byte-out handshake bundle for the 16-to-8 unpacker.
interface width_16to8_if;
  import width_pkg::*;

  logic              valid_in;
  logic [WORD_W-1:0] data_in;
  logic              ready_in;
  logic              valid_out;
  logic [BYTE_W-1:0] data_out;
  logic              ready_out;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out
  );

endinterface

// File: rtl/width_16to8.sv
// Width-down converter: each accepted 16-bit word is emitted as two
// consecutive bytes, streaming one byte per cycle when both sides allow.
module width_16to8
  import width_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  width_16to8_if.slave bus
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    bus.ready_in  = 1'b0;
    bus.valid_out = 1'b0;
    bus.data_out  = '0;

    case (state_q)
      IDLE: begin
        bus.ready_in = 1'b1;
        if (bus.valid_in) begin
          word_d  = bus.data_in;
          state_d = FIRST;
        end
      end

      FIRST: begin
        bus.valid_out = 1'b1;
        bus.data_out  = pick_byte(word_q, MSB_FIRST, 1'b1);
        if (bus.ready_out) state_d = SECOND;
      end

      SECOND: begin
        bus.valid_out = 1'b1;
        bus.data_out  = pick_byte(word_q, MSB_FIRST, 1'b0);
        // Last byte leaving frees the holding register in the same cycle,
        // which is what lets words stream without a bubble.
        bus.ready_in  = bus.ready_out;
        if (bus.ready_out) begin
          if (bus.valid_in) begin
            word_d  = bus.data_in;
            state_d = FIRST;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_width_16to8.sv
// Bench for width_16to8: directed vector table, reset corner cases and a
// randomized run against a pending-byte queue model, on both byte orders.
module tb_width_16to8;
  import width_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  width_16to8_if bm ();
  width_16to8_if bl ();

  width_16to8 #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
  width_16to8 #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bytes accepted but not yet transferred, oldest first.
  logic [7:0] qm[$];
  logic [7:0] ql[$];

  typedef struct {
    logic        vi;
    logic [15:0] d;
    logic        ro;
    logic        vo;
    logic [7:0]  dm;
    logic        ri;
    logic [7:0]  dl;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the queue model just
  // before the edge, then advance the model by what the edge should transfer.
  task automatic step(input logic vi, input logic [15:0] d, input logic ro,
                      output logic vo_m, output logic [7:0] do_m,
                      output logic ri_m, output logic [7:0] do_l);
    logic exp_ri_m, exp_ri_l, acc_m, acc_l, xf_m, xf_l;
    bm.valid_in = vi; bm.data_in = d; bm.ready_out = ro;
    bl.valid_in = vi; bl.data_in = d; bl.ready_out = ro;
    #4;
    vo_m = bm.valid_out; do_m = bm.data_out; ri_m = bm.ready_in; do_l = bl.data_out;

    exp_ri_m = (qm.size() == 0) || (qm.size() == 1 && ro);
    chk("m_valid_out", {15'd0, bm.valid_out}, {15'd0, qm.size() != 0});
    chk("m_data_out", {8'd0, bm.data_out}, {8'd0, (qm.size() != 0) ? qm[0] : 8'h00});
    chk("m_ready_in", {15'd0, bm.ready_in}, {15'd0, exp_ri_m});

    exp_ri_l = (ql.size() == 0) || (ql.size() == 1 && ro);
    chk("l_valid_out", {15'd0, bl.valid_out}, {15'd0, ql.size() != 0});
    chk("l_data_out", {8'd0, bl.data_out}, {8'd0, (ql.size() != 0) ? ql[0] : 8'h00});
    chk("l_ready_in", {15'd0, bl.ready_in}, {15'd0, exp_ri_l});

    acc_m = vi && exp_ri_m; xf_m = (qm.size() != 0) && ro;
    acc_l = vi && exp_ri_l; xf_l = (ql.size() != 0) && ro;

    @(posedge clk); #1;
    if (xf_m) void'(qm.pop_front());
    if (acc_m) begin qm.push_back(d[15:8]); qm.push_back(d[7:0]); end
    if (xf_l) void'(ql.pop_front());
    if (acc_l) begin ql.push_back(d[7:0]); ql.push_back(d[15:8]); end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid_out"}, {15'd0, bm.valid_out}, 16'd0);
    chk({tag, "_m_data_out"}, {8'd0, bm.data_out}, 16'd0);
    chk({tag, "_m_ready_in"}, {15'd0, bm.ready_in}, 16'd1);
    chk({tag, "_l_valid_out"}, {15'd0, bl.valid_out}, 16'd0);
    chk({tag, "_l_ready_in"}, {15'd0, bl.ready_in}, 16'd1);
  endtask

  initial begin
    logic       vo, ri;
    logic [7:0] dm, dl;

    tbl[0]  = '{1'b1, 16'hA55A, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h5A};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h5A, 1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 16'h5678, 1'b1, 1'b1, 8'h12, 1'b0, 8'h34};
    tbl[6]  = '{1'b1, 16'h5678, 1'b1, 1'b1, 8'h34, 1'b1, 8'h12};
    tbl[7]  = '{1'b1, 16'h9ABC, 1'b1, 1'b1, 8'h56, 1'b0, 8'h78};
    tbl[8]  = '{1'b1, 16'h9ABC, 1'b1, 1'b1, 8'h78, 1'b1, 8'h56};
    tbl[9]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h9A, 1'b0, 8'hBC};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hBC, 1'b1, 8'h9A};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[12] = '{1'b1, 16'hBEEF, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[13] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hBE, 1'b0, 8'hEF};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hBE, 1'b0, 8'hEF};
    tbl[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hBE, 1'b0, 8'hEF};
    tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hBE, 1'b0, 8'hEF};
    tbl[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 8'hBE};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 8'hEF, 1'b0, 8'hBE};
    tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hEF, 1'b1, 8'hBE};
    tbl[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[21] = '{1'b1, 16'hC0DE, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[22] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hC0, 1'b0, 8'hDE};
    tbl[23] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'hDE, 1'b1, 8'hC0};
    tbl[24] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};

    rst_n = 1'b0;
    bm.valid_in = 1'b0; bm.data_in = 16'h0; bm.ready_out = 1'b0;
    bl.valid_in = 1'b0; bl.data_in = 16'h0; bl.ready_out = 1'b0;
    #2;
    chk_reset_outputs("reset_async");
    @(posedge clk); #1;
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;

    // Idle after reset with ready_out toggling: nothing may appear.
    for (int i = 0; i < 4; i++) step(1'b0, 16'hFFFF, i[0], vo, dm, ri, dl);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].vi, tbl[i].d, tbl[i].ro, vo, dm, ri, dl);
      chk($sformatf("tbl%0d_valid_out", i), {15'd0, vo}, {15'd0, tbl[i].vo});
      chk($sformatf("tbl%0d_data_out_m", i), {8'd0, dm}, {8'd0, tbl[i].dm});
      chk($sformatf("tbl%0d_ready_in", i), {15'd0, ri}, {15'd0, tbl[i].ri});
      chk($sformatf("tbl%0d_data_out_l", i), {8'd0, dl}, {8'd0, tbl[i].dl});
    end

    // Randomized traffic with arbitrary backpressure.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60), 16'($urandom), ($urandom_range(0, 99) < 65),
           vo, dm, ri, dl);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b1, vo, dm, ri, dl);

    // Reset while the second byte of 16'h1357 is still pending.
    step(1'b1, 16'h1357, 1'b1, vo, dm, ri, dl);
    step(1'b0, 16'h0000, 1'b1, vo, dm, ri, dl);
    chk("pre_reset_first_byte", {8'd0, dm}, 16'h0013);
    bm.valid_in = 1'b0; bm.ready_out = 1'b0;
    bl.valid_in = 1'b0; bl.ready_out = 1'b0;
    #1;
    chk("pre_reset_second_byte", {8'd0, bm.data_out}, 16'h0057);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop_reset");
    qm.delete();
    ql.delete();
    @(posedge clk); #1;
    chk_reset_outputs("midop_reset_held");
    rst_n = 1'b1;

    step(1'b0, 16'h0000, 1'b1, vo, dm, ri, dl);
    step(1'b1, 16'h2468, 1'b1, vo, dm, ri, dl);
    step(1'b0, 16'h0000, 1'b1, vo, dm, ri, dl);
    chk("post_reset_byte0", {7'd0, vo, dm}, 16'h0124);
    step(1'b0, 16'h0000, 1'b1, vo, dm, ri, dl);
    chk("post_reset_byte1", {7'd0, vo, dm}, 16'h0168);
    step(1'b0, 16'h0000, 1'b1, vo, dm, ri, dl);
    chk("post_reset_idle", {7'd0, vo, dm}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
